// File: rtl/traffic_input_cond.sv
// Purpose: sync, debounce and edge-latch the emergency button and side-road sensor for the light FSM.
// Latency: raw change to level/req is 2 sync flops + DEBOUNCE_CYCLES stable samples; all outputs registered.
// Backpressure: a request is held until acked; rises arriving while held merge into the pending request.
module traffic_input_cond #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4,
    parameter int EVT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_emerg_raw,
    input  logic             sensor_raw,
    input  logic             emerg_ack,
    input  logic             sensor_ack,
    output logic             emerg_level,
    output logic             sensor_level,
    output logic             emerg_req,
    output logic             sensor_req,
    output logic [EVT_W-1:0] sensor_evt_count
);

    // Channel 0 is the emergency button, channel 1 the side-road sensor.
    localparam int CH_EMERG  = 0;
    localparam int CH_SENSOR = 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX  = '1;

    logic [1:0] raw;
    logic [1:0] ack;

    logic [1:0]            s1_q, s1_d;
    logic [1:0]            s2_q, s2_d;
    logic [1:0]            level_q, level_d;
    logic [1:0]            req_q, req_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [EVT_W-1:0]      evt_q, evt_d;
    logic [1:0]            rise;

    assign raw = {sensor_raw, btn_emerg_raw};
    assign ack = {sensor_ack, emerg_ack};

    // Next-state: synchroniser shift, debounce counter, request latch and saturating event count.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        level_d = level_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        rise    = 2'b00;

        for (int ch = 0; ch < 2; ch++) begin
            // Any sample agreeing with the current level restarts the stability window.
            if (s2_q[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = s2_q[ch];
                cnt_d[ch]   = '0;
                rise[ch]    = s2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end

            // A rise wins over a same-edge ack so a fresh event is never dropped.
            if (rise[ch]) begin
                req_d[ch] = 1'b1;
            end else if (ack[ch] && req_q[ch]) begin
                req_d[ch] = 1'b0;
            end
        end

        // Counts every sensor rise, including those merged into a pending request; never wraps.
        if (rise[CH_SENSOR] && (evt_q != EVT_MAX)) begin
            evt_d = evt_q + EVT_ONE;
        end
    end

    // State registers; reset clears everything, including any pending request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            req_q   <= '0;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign emerg_level      = level_q[CH_EMERG];
    assign sensor_level     = level_q[CH_SENSOR];
    assign emerg_req        = req_q[CH_EMERG];
    assign sensor_req       = req_q[CH_SENSOR];
    assign sensor_evt_count = evt_q;

endmodule
